led_bcd_buffer: RTL and testbench

Upstream feeder for the 8-digit 7-segment scan stage. It accepts a binary value through a valid/ready handshake and converts it to 8 BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per cycle. It applies optional leading-zero blanking and holds the resulting 5-bit digit codes in a display register. The scan stage reads one code per digit position through a select/read port.

---
 rtl/led_bcd_buffer.sv | 152 +++++++++++++++
 tb/tb_led_bcd_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_bcd_buffer.sv
// Binary-to-BCD display buffer: accepts a value over valid/ready, converts it with a
// serial double-dabble engine, applies leading-zero blanking and holds 8 digit codes.
module led_bcd_buffer #(
  parameter int         BIN_W      = 27,
  parameter logic [4:0] CODE_BLANK = 5'h1E,
  parameter logic [4:0] CODE_ERR   = 5'h0E
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_data,
  input  logic             blank_lz,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [39:0]      dig_codes,
  input  logic [2:0]       rd_sel,
  output logic [4:0]       rd_code
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  localparam logic [31:0] MAX_VAL = 32'd99_999_999;
  localparam logic [4:0]  LAST    = 5'(BIN_W - 1);

  state_t           state;
  logic [BIN_W-1:0] bin;
  logic [31:0]      bcd;
  logic [31:0]      bcd_adj;
  logic [31:0]      in_wide;
  logic [4:0]       cnt;
  logic             blank;
  logic             ovf_pend;
  logic [39:0]      codes_next;

  // Add 3 to every nibble that is 5 or more, so the following shift carries correctly.
  function automatic logic [31:0] dabble_adj(input logic [31:0] v);
    logic [31:0] r;
    logic [3:0]  nib;
    r = 32'd0;
    for (int i = 0; i < 8; i++) begin
      nib = v[4*i +: 4];
      if (nib >= 4'd5) begin
        r[4*i +: 4] = nib + 4'd3;
      end else begin
        r[4*i +: 4] = nib;
      end
    end
    return r;
  endfunction

  assign bcd_adj = dabble_adj(bcd);
  assign in_wide = 32'(in_data);

  // Digit codes for the finished conversion, with leading zeros blanked from digit 7 down.
  always_comb begin
    logic       lead;
    logic [3:0] nib;
    lead       = 1'b1;
    nib        = 4'd0;
    codes_next = {8{CODE_BLANK}};
    for (int i = 7; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (ovf_pend) begin
        codes_next[5*i +: 5] = CODE_ERR;
      end else if (blank && lead && (nib == 4'd0) && (i != 0)) begin
        codes_next[5*i +: 5] = CODE_BLANK;
      end else begin
        codes_next[5*i +: 5] = {1'b0, nib};
        lead = 1'b0;
      end
    end
  end

  // Control FSM, shift-add-3 datapath and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= 32'd0;
      cnt       <= 5'd0;
      blank     <= 1'b0;
      ovf_pend  <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      dig_codes <= {8{CODE_BLANK}};
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (in_valid) begin
            bin      <= in_data;
            bcd      <= 32'd0;
            cnt      <= 5'd0;
            blank    <= blank_lz;
            ovf_pend <= (in_wide > MAX_VAL);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          done <= 1'b0;
          bcd  <= {bcd_adj[30:0], bin[BIN_W-1]};
          bin  <= bin << 1;
          cnt  <= cnt + 5'd1;
          if (cnt == LAST) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          dig_codes <= codes_next;
          ovf       <= ovf_pend;
          done      <= 1'b1;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          done     <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Scanner read port.
  always_comb begin
    rd_code = CODE_BLANK;
    case (rd_sel)
      3'd0:    rd_code = dig_codes[4:0];
      3'd1:    rd_code = dig_codes[9:5];
      3'd2:    rd_code = dig_codes[14:10];
      3'd3:    rd_code = dig_codes[19:15];
      3'd4:    rd_code = dig_codes[24:20];
      3'd5:    rd_code = dig_codes[29:25];
      3'd6:    rd_code = dig_codes[34:30];
      3'd7:    rd_code = dig_codes[39:35];
      default: rd_code = CODE_BLANK;
    endcase
  end

endmodule

// File: tb/tb_led_bcd_buffer.sv
// Bench for led_bcd_buffer: arithmetic reference model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_led_bcd_buffer;

  localparam int BIN_W = 27;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, blank_lz, busy, done, ovf;
  logic [BIN_W-1:0] in_data;
  logic [39:0]      dig_codes;
  logic [2:0]       rd_sel;
  logic [4:0]       rd_code;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit armed = 1'b0;

  // reference model state
  int          m_cnt = 0;
  longint      m_val = 0;
  bit          m_blank = 1'b0;
  logic [39:0] m_codes = '0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;

  led_bcd_buffer #(.BIN_W(BIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .blank_lz(blank_lz), .busy(busy), .done(done), .ovf(ovf),
    .dig_codes(dig_codes), .rd_sel(rd_sel), .rd_code(rd_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [39:0] expect_codes(input longint v, input bit blz);
    logic [39:0] r;
    longint      d;
    longint      p;
    bit          lead;
    r = '0;
    if (v > 64'd99_999_999) return {8{5'h0E}};
    lead = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      d = (v / p) % 10;
      if (blz && lead && d == 0 && i != 0) r[5*i +: 5] = 5'h1E;
      else begin
        r[5*i +: 5] = 5'(d);
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  // Model: count edges since acceptance; the display updates BIN_W+1 edges later.
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (!rst_n) begin
      m_cnt   <= 0;
      m_codes <= {8{5'h1E}};
      m_ovf   <= 1'b0;
    end else if (m_cnt == 0) begin
      if (in_valid) begin
        m_cnt   <= 1;
        m_val   <= longint'(in_data);
        m_blank <= blank_lz;
      end
    end else if (m_cnt <= BIN_W) begin
      m_cnt <= m_cnt + 1;
    end else begin
      m_codes <= expect_codes(m_val, m_blank);
      m_ovf   <= (m_val > 64'd99_999_999);
      m_done  <= 1'b1;
      m_cnt   <= 0;
    end
  end

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("done", 40'(done), 40'(m_done));
      chk("in_ready", 40'(in_ready), 40'(m_cnt == 0));
      chk("busy", 40'(busy), 40'(m_cnt != 0));
      chk("ovf", 40'(ovf), 40'(m_ovf));
      chk("dig_codes", dig_codes, m_codes);
      chk("rd_code", 40'(rd_code), 40'(m_codes[int'(rd_sel)*5 +: 5]));
    end
  end

  task automatic wait_accept(output int acc);
    bit ok;
    ok  = 1'b0;
    acc = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        ok  = 1'b1;
      end
    end
    if (!ok) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL accept_timeout actual=no_accept expected=accept");
    end
  endtask

  task automatic send(input longint v, input bit blz, output int acc);
    in_valid = 1'b1;
    in_data  = BIN_W'(v);
    blank_lz = blz;
    wait_accept(acc);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    bit ok;
    ok   = 1'b0;
    dcyc = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      #1;
      if (done) begin
        dcyc = cyc;
        ok   = 1'b1;
      end
      rd_sel = rd_sel + 3'd1;
    end
    if (!ok) begin
      checks = checks + 1;
      failures = failures + 1;
      $display("FAIL done_timeout actual=no_done expected=done");
    end
  endtask

  initial begin
    int acc, acc2, dc, npulse;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; blank_lz = 1'b0; rd_sel = 3'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    armed = 1'b1;

    // 1: reset state
    for (int i = 0; i < 8; i++) begin
      rd_sel = 3'(i);
      #1 chk("reset_rd_code", 40'(rd_code), 40'h1E);
    end
    chk("reset_ready", 40'(in_ready), 40'd1);
    chk("reset_done", 40'(done), 40'd0);
    chk("reset_ovf", 40'(ovf), 40'd0);

    // 2: 12_345_678 with blanking, latency 28
    send(64'd12_345_678, 1'b1, acc);
    wait_done(dc);
    chk("latency", 40'(dc - acc), 40'd28);
    chk("val_12345678", dig_codes, {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8});
    chk("ovf_12345678", 40'(ovf), 40'd0);

    // 3: zero with blanking, then 100 without
    send(64'd0, 1'b1, acc);
    wait_done(dc);
    chk("val_0_blank", dig_codes, {{7{5'h1E}}, 5'h00});
    send(64'd100, 1'b0, acc);
    wait_done(dc);
    chk("val_100_noblank", dig_codes, {5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0});

    // 4: overflow boundary
    send(64'd100_000_000, 1'b1, acc);
    wait_done(dc);
    chk("val_ovf_codes", dig_codes, {8{5'h0E}});
    chk("val_ovf_flag", 40'(ovf), 40'd1);
    send(64'd99_999_999, 1'b1, acc);
    wait_done(dc);
    chk("val_max_codes", dig_codes, {8{5'h09}});
    chk("val_max_ovf", 40'(ovf), 40'd0);

    // 5: in_valid held high, back-to-back acceptance
    in_valid = 1'b1; in_data = 27'd5; blank_lz = 1'b1;
    wait_accept(acc);
    in_data = 27'd42;
    wait_accept(acc2);
    in_valid = 1'b0;
    chk("b2b_gap", 40'(acc2 - acc), 40'd29);
    wait_done(dc);
    chk("val_42", dig_codes, {{6{5'h1E}}, 5'd4, 5'd2});

    // 6: reset during a conversion
    send(64'd777, 1'b1, acc);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_busy", 40'(busy), 40'd0);
    chk("abort_codes", dig_codes, {8{5'h1E}});
    npulse = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) npulse = npulse + 1;
    end
    chk("abort_no_done", 40'(npulse), 40'd0);
    send(64'd3, 1'b1, acc);
    wait_done(dc);
    chk("val_3_after_abort", dig_codes, {{7{5'h1E}}, 5'd3});

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
